shift_issue_stage: RTL
======================

# shift_issue_stage

Pipelined request front-end for the ALU shift path: accepts shift requests over a valid/ready handshake, registers operands, and drives the combinational right-shift datapath. Logical left shifts use bit-reversal around the right shifter. Results are returned over a second valid/ready handshake. Sits between the ALU server's request decoder and its response mux; full throughput of one request per cycle.

## Interface
- TAG_W, 4: width of the request tag carried alongside each operation
- CNT_W, 16: width of completed-operation counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  stage can accept request this cycle
- req_op  in  3  operation code (shift_pkg::shift_op_t)
- req_data  in  32  operand
- req_shamt  in  5  shift amount 0..31
- req_tag  in  TAG_W  opaque tag, returned unchanged
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  shift result
- rsp_tag  out  TAG_W  tag of this result
- rsp_err  out  1  illegal opcode flag
- busy  out  1  any pipeline stage occupied
- ops_done  out  CNT_W  count of responses handed off (rsp_valid & rsp_ready)

## Operation
- Opcodes: SH_SLL=0, SH_SRL=1, SH_SRA=2, SH_ROR=3, SH_ROL=4; 5..7 illegal.
- SRL: right shift, zero fill. SRA: right shift, fill = req_data[31].
- SLL: bit-reverse operand, logical right shift by shamt, bit-reverse result.
- Illegal op (or rotate op with rotate compiled out): rsp_data=0, rsp_err=1, tag still returned.
- Two registered stages. S1 holds op/data/shamt/tag. S2 holds data/tag/err computed from S1 by shift_core.
- s2_adv = !s2_valid | rsp_ready. s1_adv = !s1_valid | s2_adv. req_ready = s1_adv (combinational through both stages).
- Transfer on req_valid & req_ready loads S1. S1 moves to S2 when s1_valid & s2_adv. A stage whose contents leave and receive no replacement clears its valid bit.
- Results leave strictly in acceptance order; no reordering, no drops.
- ops_done increments on each rsp handshake and wraps from 2^CNT_W-1 to 0.
- busy = s1_valid | s2_valid.

## Timing
- Latency: request accepted at cycle N → rsp_valid at cycle N+2, when not backpressured.
- Throughput: one request per cycle while rsp_ready is held high.
- rsp_data/rsp_tag/rsp_err are stable while rsp_valid & !rsp_ready.
- Full: both stages valid and rsp_ready=0 → req_ready=0. Same-cycle rsp_ready=1 re-enables req_ready in that cycle.
- Empty: req_ready=1.
- Reset, applied at any point including mid-operation, takes effect at the next edge:
  - s1_valid, s2_valid, rsp_valid, busy = 0
  - rsp_data = 0, rsp_tag = 0, rsp_err = 0, ops_done = 0
  - In-flight requests are discarded.
- req_ready is 0 while rst is high.
- shamt=0 on any op returns req_data unchanged.

## Configuration
- SHIFT_ROT_EN defined:
  - SH_ROR = srl(x,s) | sll(x,(32-s) mod 32), with the sll term forced to 0 when s=0.
  - SH_ROL is built the same way, mirrored.
  - Uses a second right-shifter instance inside shift_core.
- SHIFT_ROT_EN undefined: opcodes 3 and 4 are illegal (rsp_err=1, rsp_data=0); single shifter instance.

## Structure
- shift_pkg holds:
  - shift_op_t enum (3-bit) with the values above
  - constant SHIFT_W = 32
  - function bit_rev32
- One sub-module, shift_core: combinational op decode, bit-reversal, right-shifter instance(s), err generation.
- shift_issue_stage contains only the two stage registers, handshake logic and counter.

## Test plan
- SRA 0x8000_0000 by 4, tag 3 → rsp_data 0xF800_0000, rsp_tag 3, rsp_err 0, two cycles after accept.
- SLL 0x0000_0001 by 31 → 0x8000_0000. SRL 0x8000_0000 by 31 → 0x0000_0001. Any op with shamt 0 on 0xDEAD_BEEF → 0xDEAD_BEEF.
- Back-to-back stream of 8 requests with rsp_ready=1 → 8 consecutive rsp_valid cycles, tags in order, ops_done=8.
- Backpressure:
  - Hold rsp_ready=0 and offer 3 requests → only 2 accepted, req_ready=0 on the third, rsp outputs stable.
  - Raise rsp_ready → all 3 delivered in order.
- Op 7 on 0x1234_5678 → rsp_err=1, rsp_data=0. With SHIFT_ROT_EN, ROR 0x1234_5678 by 8 → 0x7812_3456 and ROL by 8 → 0x3456_7812; without it, both → rsp_err=1.
- Assert rst with both stages full → next cycle rsp_valid=0, busy=0, ops_done=0, req_ready=1 after rst drops; no stale response appears.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the ALU shift issue path (operand width, opcodes, bit reversal).
// Latency: none, declarations only.
// Backpressure: none, declarations only. SHIFT_ROT_EN enables the rotate opcodes in shift_core.
package shift_pkg;

   localparam int SHIFT_W = 32;

   typedef enum logic [2:0] {
      SH_SLL = 3'd0,
      SH_SRL = 3'd1,
      SH_SRA = 3'd2,
      SH_ROR = 3'd3,
      SH_ROL = 3'd4
   } shift_op_t;

   // Request payload held in the first stage. The opcode is kept raw so that
   // illegal codes 5..7 travel to the decoder untouched.
   typedef struct packed {
      logic [2:0]         op;
      logic [SHIFT_W-1:0] data;
      logic [4:0]         shamt;
   } shift_req_t;

   // Mirror a word end for end so the right shifter can also do left shifts.
   function automatic logic [SHIFT_W-1:0] bit_rev32(input logic [SHIFT_W-1:0] x);
      logic [SHIFT_W-1:0] r;
      for (int i = 0; i < SHIFT_W; i++) begin
         r[i] = x[SHIFT_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational shift datapath: opcode decode, bit reversal around right shifter(s), illegal-op flag.
// Latency: zero cycles, purely combinational.
// Backpressure: none; SHIFT_ROT_EN adds a second right shifter for ROR/ROL, otherwise opcodes 3/4 are illegal.
module shift_core
   import shift_pkg::*;
(
   input  logic [2:0]         op,
   input  logic [SHIFT_W-1:0] data,
   input  logic [4:0]         shamt,
   output logic [SHIFT_W-1:0] res,
   output logic               err
);

   logic [SHIFT_W-1:0] rev_data;
   logic [SHIFT_W-1:0] pri_in;
   logic               pri_fill;
   logic [SHIFT_W-1:0] pri_out;

   assign rev_data = bit_rev32(data);

   // Primary shifter input select: left-going ops feed the reversed operand, SRA picks the sign as fill.
   always_comb begin
      pri_in   = data;
      pri_fill = 1'b0;
      case (op)
         SH_SLL:  pri_in   = rev_data;
         SH_SRA:  pri_fill = data[SHIFT_W-1];
`ifdef SHIFT_ROT_EN
         SH_ROL:  pri_in   = rev_data;
`endif
         default: ;
      endcase
   end

   // Right shifter; a ones fill is produced by shifting the complement and complementing back.
   assign pri_out = pri_fill ? ~((~pri_in) >> shamt) : (pri_in >> shamt);

`ifdef SHIFT_ROT_EN
   logic [4:0]         sec_amt;
   logic [SHIFT_W-1:0] sec_in;
   logic [SHIFT_W-1:0] sec_out;
   logic [SHIFT_W-1:0] rot_term;

   // The wrap-around part of a rotate is a shift by (32 - shamt) mod 32 in the opposite direction.
   assign sec_amt = 5'd0 - shamt;
   assign sec_in  = (op == SH_ROR) ? rev_data : data;
   assign sec_out = sec_in >> sec_amt;

   // Wrap term is empty for shamt 0: the primary shifter already returns the whole word.
   always_comb begin
      rot_term = '0;
      if (shamt != 5'd0) begin
         rot_term = (op == SH_ROR) ? bit_rev32(sec_out) : sec_out;
      end
   end
`endif

   // Result assembly and illegal-op flagging; illegal ops return zero data.
   always_comb begin
      res = '0;
      err = 1'b0;
      case (op)
         SH_SLL:         res = bit_rev32(pri_out);
         SH_SRL, SH_SRA: res = pri_out;
`ifdef SHIFT_ROT_EN
         SH_ROR:         res = pri_out | rot_term;
         SH_ROL:         res = bit_rev32(pri_out) | rot_term;
`endif
         default:        err = 1'b1;
      endcase
   end

endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage issue pipeline for shift requests: S1 registers the request, S2 registers the shift_core result.
// Latency: accept at cycle N gives rsp_valid at N+2; one request per cycle sustained while rsp_ready is high.
// Backpressure: req_ready = !s1_valid | !s2_valid | rsp_ready (combinational through both stages); SHIFT_ROT_EN enables ROR/ROL.
module shift_issue_stage
   import shift_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          req_op,
   input  logic [SHIFT_W-1:0]  req_data,
   input  logic [4:0]          req_shamt,
   input  logic [TAG_W-1:0]    req_tag,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [SHIFT_W-1:0]  rsp_data,
   output logic [TAG_W-1:0]    rsp_tag,
   output logic                rsp_err,
   output logic                busy,
   output logic [CNT_W-1:0]    ops_done
);

   logic               s1_valid;
   shift_req_t         s1_req;
   logic [TAG_W-1:0]   s1_tag;
   logic               s2_valid;
   logic               s1_adv;
   logic               s2_adv;
   logic [SHIFT_W-1:0] core_res;
   logic               core_err;

   // A stage may take new contents when it is empty or its current contents leave this cycle.
   assign s2_adv    = !s2_valid | rsp_ready;
   assign s1_adv    = !s1_valid | s2_adv;
   assign req_ready = s1_adv & !rst;

   assign rsp_valid = s2_valid;
   assign busy      = s1_valid | s2_valid;

   shift_core u_core (
      .op    (s1_req.op),
      .data  (s1_req.data),
      .shamt (s1_req.shamt),
      .res   (core_res),
      .err   (core_err)
   );

   // S1: capture an accepted request; drop valid when contents move on without a replacement.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
         s1_tag   <= '0;
      end else if (s1_adv) begin
         s1_valid <= req_valid;
         if (req_valid) begin
            s1_req.op    <= req_op;
            s1_req.data  <= req_data;
            s1_req.shamt <= req_shamt;
            s1_tag       <= req_tag;
         end
      end
   end

   // S2: capture the shift result; contents are frozen while stalled so rsp fields stay stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         rsp_data <= '0;
         rsp_tag  <= '0;
         rsp_err  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            rsp_data <= core_res;
            rsp_tag  <= s1_tag;
            rsp_err  <= core_err;
         end
      end
   end

   // Completed-response counter, wraps naturally at its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         ops_done <= '0;
      end else if (s2_valid && rsp_ready) begin
         ops_done <= ops_done + 1'b1;
      end
   end

endmodule
